seq_div_32: RTL and testbench

SEQ_DIV_32 -- requirements
Module: seq_div_32

---
 rtl/seq_div_32.sv | 187 ++++++++++++++++++
 tb/tb_seq_div_32.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_32.sv
// -----------------------------------------------------------------------------
// seq_div_32 -- sequential restoring divider, one quotient bit per clock.
//
// A divide is requested with start while the unit is IDLE or DONE. The
// operands are captured on that edge. The unit then iterates for WIDTH
// cycles in BUSY and spends one cycle in DONE with the results on the
// outputs. The results stay on the outputs until the next accepted
// operation completes.
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   rst        in   synchronous, active-high reset
//   start      in   divide request (ignored while BUSY)
//   operand1   in   [WIDTH-1:0] dividend
//   operand2   in   [WIDTH-1:0] divisor
//   signedOp   in   1 = two's-complement divide (SEQ_DIV_SIGNED_EN builds only)
//   busy       out  high while iterating
//   done       out  one-cycle completion pulse
//   quotient   out  [WIDTH-1:0] registered quotient
//   remainder  out  [WIDTH-1:0] registered remainder
//   divByZero  out  registered divide-by-zero flag
//
// Configuration:
//   SEQ_DIV_SIGNED_EN  when defined, signedOp=1 selects truncating signed
//                      division (the quotient rounds toward zero and the
//                      remainder takes the dividend's sign). When it is not
//                      defined, signedOp is ignored and every divide is
//                      unsigned.
//
// Handshake: start is a request that is consumed on any rising edge where the
// unit is IDLE or DONE. There is no backpressure. busy tells the requester that
// a start would be dropped. done marks the single cycle in which a new result
// first appears.
// -----------------------------------------------------------------------------
module seq_div_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             signedOp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dividendReg;  // dividend bits shift out at the top and quotient bits shift in at the bottom
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] partRem;
    logic             negQuo;
    logic             negRem;

    // One restoring step. The partial remainder is always below the divisor,
    // so the trial value fits in WIDTH+1 bits. When the subtract succeeds, the
    // difference fits back into WIDTH bits.
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] nextRem;
    logic [WIDTH-1:0] nextQuo;
    logic [WIDTH-1:0] finalQuo;
    logic [WIDTH-1:0] finalRem;
    logic             sign1;
    logic             sign2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic             unusedDiffMsb;

    assign unusedDiffMsb = diff[WIDTH];

    always_comb begin
        trial   = {partRem, dividendReg[WIDTH-1]};
        diff    = trial - {1'b0, divisorReg};
        fits    = (trial >= {1'b0, divisorReg});
        nextRem = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        nextQuo = {dividendReg[WIDTH-2:0], fits};
    end

`ifdef SEQ_DIV_SIGNED_EN
    // The divide runs on magnitudes. The signs are applied on the completion
    // edge. The most negative value is its own magnitude when it is read as
    // unsigned, so it needs no special case.
    always_comb begin
        sign1    = signedOp & operand1[WIDTH-1];
        sign2    = signedOp & operand2[WIDTH-1];
        mag1     = sign1 ? -operand1 : operand1;
        mag2     = sign2 ? -operand2 : operand2;
        finalQuo = negQuo ? -nextQuo : nextQuo;
        finalRem = negRem ? -nextRem : nextRem;
    end
`else
    logic unusedSignedOp;
    assign unusedSignedOp = signedOp;

    always_comb begin
        sign1    = 1'b0;
        sign2    = 1'b0;
        mag1     = operand1;
        mag2     = operand2;
        finalQuo = nextQuo;
        finalRem = nextRem;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            dividendReg <= '0;
            divisorReg  <= '0;
            partRem     <= '0;
            negQuo      <= 1'b0;
            negRem      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            divByZero   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (operand2 == '0) begin
                            // A zero divisor skips the iteration and completes on the accept edge.
                            quotient  <= '1;
                            remainder <= operand1;
                            divByZero <= 1'b1;
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            dividendReg <= mag1;
                            divisorReg  <= mag2;
                            partRem     <= '0;
                            count       <= '0;
                            negQuo      <= sign1 ^ sign2;
                            negRem      <= sign1;
                            state       <= BUSY;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end

                BUSY: begin
                    dividendReg <= nextQuo;
                    partRem     <= nextRem;
                    count       <= count + 1'b1;
                    if (count == LAST) begin
                        quotient  <= finalQuo;
                        remainder <= finalRem;
                        divByZero <= 1'b0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_32.sv
module tb_seq_div_32;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         signed_op;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int busy_cnt = 0;

    logic [W-1:0] exp_quo_q[$];
    logic [W-1:0] exp_rem_q[$];
    logic [W-1:0] exp_dbz_q[$];
    logic [W-1:0] exp_cyc_q[$];
    logic [W-1:0] exp_busy_q[$];

    seq_div_32 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .operand1  (op1),
        .operand2  (op2),
        .signedOp  (signed_op),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .divByZero (div_by_zero)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request at the current negedge. It is accepted on the next
    // rising edge. With track set, the expected response goes to the scoreboard.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input bit track);
        op1 = a;
        op2 = b;
        signed_op = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) begin
            exp_quo_q.push_back(eq);
            exp_rem_q.push_back(er);
            exp_dbz_q.push_back(W'(edz));
            exp_cyc_q.push_back(W'(cyc + ((b == '0) ? 0 : W)));
            exp_busy_q.push_back((b == '0) ? W'(0) : W'(W));
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            if (exp_quo_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                check("quotient", quotient, exp_quo_q.pop_front());
                check("remainder", remainder, exp_rem_q.pop_front());
                check("div_by_zero", W'(div_by_zero), exp_dbz_q.pop_front());
                check("done_cycle", W'(cyc), exp_cyc_q.pop_front());
                check("busy_cycles", W'(busy_cnt), exp_busy_q.pop_front());
                check("busy_with_done", W'(busy), W'(0));
            end
            busy_cnt = 0;
        end else if (!busy) begin
            busy_cnt = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst = 1'b1;
        start = 1'b0;
        op1 = '0;
        op2 = '0;
        signed_op = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_quotient", quotient, W'(0));
        check("rst_remainder", remainder, W'(0));
        check("rst_dbz", W'(div_by_zero), W'(0));

        // basic unsigned divide
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1);
        wait_done("t100_7");

        // back-to-back: all-ones / 1, then a divide by zero accepted in DONE
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        wait_done("tmax_1");
        issue(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        wait_done("t5_0");

        // start while busy is ignored; the previous results are held during BUSY
        @(negedge clk);
        issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 1);
        repeat (5) @(negedge clk);
        check("hold_busy", W'(busy), W'(1));
        check("hold_quotient", quotient, 32'hFFFF_FFFF);
        check("hold_remainder", remainder, 32'd5);
        check("hold_dbz", W'(div_by_zero), W'(1));
        op1 = 32'd9;
        op2 = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        op1 = 32'h1234_5678;
        op2 = 32'd17;
        wait_done("t1000_10");
        repeat (40) @(negedge clk);

        // signed handling
`ifdef SEQ_DIV_SIGNED_EN
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1);
        wait_done("tneg7_2");
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1);
        wait_done("tmin_neg1");
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1);
        wait_done("t7_neg2");
`else
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 1);
        wait_done("tneg7_2");
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 1);
        wait_done("tmin_neg1");
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0, 1);
        wait_done("t7_neg2");
`endif

        // boundary operands
        issue(32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0, 1);
        wait_done("t3_10");
        issue(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1);
        wait_done("t0_5");
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 1);
        wait_done("tmax_max");
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 1);
        wait_done("tmin_max_unsigned");

        // reset aborts an operation in progress
        @(negedge clk);
        issue(32'd1000, 32'd10, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_quotient", quotient, W'(0));
        check("abort_remainder", remainder, W'(0));
        check("abort_dbz", W'(div_by_zero), W'(0));
        repeat (40) @(negedge clk);
        issue(32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0, 1);
        wait_done("t50_6");

        // random unsigned pairs, each issued back-to-back from DONE
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == '0) b = 32'd1;
            issue(a, b, 1'b0, a / b, a % b, 1'b0, 1);
            wait_done("trand");
        end

        repeat (5) @(negedge clk);
        check("queue_drained", W'(exp_quo_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
